// File: rtl/prefetch_buffer_controller.sv
// Instruction prefetch controller: fetches sequential words from the
// instruction memory into a small circular FIFO. The pipeline is frozen with
// out_InstructionWait while the FIFO is empty. A PC change flushes the FIFO.
// A fetch that is still waiting on memory at that moment is carried to
// completion, and its data is then dropped in the DISCARD state.
//
// Memory handshake: out_MemRequest is the valid and in_MemWait is the inverted
// ready. A fetch completes in the cycle where request=1 and wait=0. Once
// raised, a request holds its address until it completes. Pipeline handshake:
// out_InstructionWait is the inverted valid and in_PipelineStall is the
// inverted ready. The head entry is consumed when both are low.
module prefetch_buffer_controller #(
  parameter int            DEPTH    = 4,
  parameter int            IW       = 32,
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  output logic          out_MemRequest,
  output logic [AW-1:0] out_MemAddress,
  input  logic [IW-1:0] in_MemData,
  input  logic          in_MemWait,
  output logic [IW-1:0] out_Instruction,
  output logic [AW-1:0] out_InstructionAddress,
  output logic          out_InstructionWait,
  input  logic          in_PipelineStall,
  input  logic          in_ChangePC,
  input  logic [AW-1:0] in_NewPC,
  output logic          fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] hold_addr;
  logic          pending;

  logic [AW-1:0] addr_buf [DEPTH];
  logic [IW-1:0] inst_buf [DEPTH];

  logic request_raw;
  logic done;
  logic stalled;
  logic push;
  logic pop;
  logic empty;

  assign fsm_state = state;
  assign empty     = (count == '0);

  // Request logic: in FETCH a request is raised only while there is room, and
  // a request that is stalled by memory is held. In DISCARD the abandoned
  // request is always still outstanding. Reset forces the request low at once.
  always_comb begin
    request_raw = 1'b1;
    if (state == FETCH) begin
      request_raw = (count < CW'(DEPTH)) || pending;
    end
  end

  assign out_MemRequest = reset & request_raw;
  assign out_MemAddress = (state == DISCARD) ? hold_addr : fetch_pc;

  assign done    = out_MemRequest & ~in_MemWait;
  assign stalled = out_MemRequest & in_MemWait;
  assign push    = (state == FETCH) & done & ~in_ChangePC;

  assign out_InstructionWait    = empty | in_ChangePC;
  assign pop                    = ~out_InstructionWait & ~in_PipelineStall;
  assign out_Instruction        = empty ? '0 : inst_buf[rd_ptr];
  assign out_InstructionAddress = empty ? '0 : addr_buf[rd_ptr];

  // FIFO storage write: an {address, instruction} pair is written on each push.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_buf[wr_ptr] <= fetch_pc;
      inst_buf[wr_ptr] <= in_MemData;
    end
  end

  // Control FSM, pointers, count and fetch PC. A PC change overrides any push
  // or pop in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fetch_pc  <= RESET_PC;
      hold_addr <= '0;
      pending   <= 1'b0;
    end else begin
      pending <= stalled;
      if (in_ChangePC) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= {in_NewPC[AW-1:2], 2'b00};
        if (stalled && state == FETCH) begin
          hold_addr <= fetch_pc;
        end
        state <= stalled ? DISCARD : FETCH;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          fetch_pc <= fetch_pc + AW'(4);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
        if (state == DISCARD && done) begin
          state <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_prefetch_buffer_controller.sv
// Directed bench for prefetch_buffer_controller. Memory is modelled as
// always returning mem_word(address), so every buffered instruction can be
// predicted from its address.
module tb_prefetch_buffer_controller;

  localparam int AW = 32;
  localparam int IW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          out_MemRequest;
  logic [AW-1:0] out_MemAddress;
  logic [IW-1:0] in_MemData;
  logic          in_MemWait = 1'b0;
  logic [IW-1:0] out_Instruction;
  logic [AW-1:0] out_InstructionAddress;
  logic          out_InstructionWait;
  logic          in_PipelineStall = 1'b1;
  logic          in_ChangePC = 1'b0;
  logic [AW-1:0] in_NewPC = '0;
  logic          fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  prefetch_buffer_controller #(
    .DEPTH(4), .IW(IW), .AW(AW), .RESET_PC(32'h0)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .out_MemRequest        (out_MemRequest),
    .out_MemAddress        (out_MemAddress),
    .in_MemData            (in_MemData),
    .in_MemWait            (in_MemWait),
    .out_Instruction       (out_Instruction),
    .out_InstructionAddress(out_InstructionAddress),
    .out_InstructionWait   (out_InstructionWait),
    .in_PipelineStall      (in_PipelineStall),
    .in_ChangePC           (in_ChangePC),
    .in_NewPC              (in_NewPC),
    .fsm_state             (fsm_state)
  );

  // Clock generation
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_00A5;
  endfunction

  assign in_MemData = mem_word(out_MemAddress);

  // Each cycle: inputs are driven 2ns after the rising edge, outputs are
  // sampled 3ns later on the falling edge.
  task automatic next_cycle;
    @(posedge clock);
    #2;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic apply_reset;
    @(posedge clock);
    #2;
    reset = 1'b0;
    in_MemWait = 1'b0;
    in_PipelineStall = 1'b1;
    in_ChangePC = 1'b0;
    in_NewPC = '0;
    @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    #3;
    n_checks++; if (out_MemRequest !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", out_MemRequest); end
    n_checks++; if (out_InstructionWait !== 1'b1) begin n_fail++; $display("FAIL reset_iwait: got %b want 1", out_InstructionWait); end
    n_checks++; if (out_Instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", out_Instruction); end
    n_checks++; if (out_InstructionAddress !== 32'h0) begin n_fail++; $display("FAIL reset_iaddr: got %h want 0", out_InstructionAddress); end
    n_checks++; if (fsm_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", fsm_state); end
  endtask

  task automatic test_fetch_from_reset;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      settle();
      n_checks++; if (out_MemRequest !== 1'b1) begin n_fail++; $display("FAIL fetch_req[%0d]: got %b want 1", k, out_MemRequest); end
      n_checks++; if (out_MemAddress !== 32'(4 * k)) begin n_fail++; $display("FAIL fetch_addr[%0d]: got %h want %h", k, out_MemAddress, 32'(4 * k)); end
      if (k == 0) begin
        n_checks++; if (out_InstructionWait !== 1'b1) begin n_fail++; $display("FAIL fetch_iwait0: got %b want 1", out_InstructionWait); end
        n_checks++; if (out_Instruction !== 32'h0) begin n_fail++; $display("FAIL fetch_empty_instr: got %h want 0", out_Instruction); end
      end else begin
        n_checks++; if (out_InstructionWait !== 1'b0) begin n_fail++; $display("FAIL fetch_iwait[%0d]: got %b want 0", k, out_InstructionWait); end
        n_checks++; if (out_Instruction !== mem_word(32'h0)) begin n_fail++; $display("FAIL fetch_head_instr[%0d]: got %h want %h", k, out_Instruction, mem_word(32'h0)); end
        n_checks++; if (out_InstructionAddress !== 32'h0) begin n_fail++; $display("FAIL fetch_head_addr[%0d]: got %h want 0", k, out_InstructionAddress); end
      end
      next_cycle();
    end
    settle();
    n_checks++; if (out_MemRequest !== 1'b0) begin n_fail++; $display("FAIL fetch_full_req: got %b want 0", out_MemRequest); end
  endtask

  task automatic test_full_with_pop;
    apply_reset();
    repeat (4) next_cycle();
    in_PipelineStall = 1'b0;
    settle();
    n_checks++; if (out_MemRequest !== 1'b0) begin n_fail++; $display("FAIL full_req: got %b want 0", out_MemRequest); end
    n_checks++; if (out_InstructionAddress !== 32'h0) begin n_fail++; $display("FAIL full_head: got %h want 0", out_InstructionAddress); end
    next_cycle();
    in_PipelineStall = 1'b1;
    settle();
    n_checks++; if (out_InstructionAddress !== 32'h4) begin n_fail++; $display("FAIL pop_head_addr: got %h want 4", out_InstructionAddress); end
    n_checks++; if (out_Instruction !== mem_word(32'h4)) begin n_fail++; $display("FAIL pop_head_instr: got %h want %h", out_Instruction, mem_word(32'h4)); end
    n_checks++; if (out_MemRequest !== 1'b1) begin n_fail++; $display("FAIL pop_req: got %b want 1", out_MemRequest); end
    n_checks++; if (out_MemAddress !== 32'h10) begin n_fail++; $display("FAIL pop_req_addr: got %h want 10", out_MemAddress); end
    next_cycle();
    settle();
    n_checks++; if (out_MemRequest !== 1'b0) begin n_fail++; $display("FAIL refull_req: got %b want 0", out_MemRequest); end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    next_cycle();
    next_cycle();
    in_PipelineStall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      settle();
      n_checks++; if (out_InstructionWait !== 1'b0) begin n_fail++; $display("FAIL b2b_iwait[%0d]: got %b want 0", k, out_InstructionWait); end
      n_checks++; if (out_InstructionAddress !== 32'(4 * k)) begin n_fail++; $display("FAIL b2b_head[%0d]: got %h want %h", k, out_InstructionAddress, 32'(4 * k)); end
      n_checks++; if (out_Instruction !== mem_word(32'(4 * k))) begin n_fail++; $display("FAIL b2b_instr[%0d]: got %h want %h", k, out_Instruction, mem_word(32'(4 * k))); end
      n_checks++; if (out_MemAddress !== 32'(8 + 4 * k)) begin n_fail++; $display("FAIL b2b_fetch[%0d]: got %h want %h", k, out_MemAddress, 32'(8 + 4 * k)); end
      next_cycle();
    end
    in_PipelineStall = 1'b1;
    settle();
    n_checks++; if (out_InstructionAddress !== 32'h20) begin n_fail++; $display("FAIL b2b_end_head: got %h want 20", out_InstructionAddress); end
    n_checks++; if (out_MemAddress !== 32'h28) begin n_fail++; $display("FAIL b2b_end_fetch: got %h want 28", out_MemAddress); end
  endtask

  task automatic test_flush_during_wait;
    apply_reset();
    next_cycle();
    next_cycle();
    in_MemWait = 1'b1;
    settle();
    n_checks++; if (out_MemAddress !== 32'h8) begin n_fail++; $display("FAIL fdw_pending_addr: got %h want 8", out_MemAddress); end
    next_cycle();
    in_ChangePC = 1'b1;
    in_NewPC = 32'h103;
    settle();
    n_checks++; if (out_InstructionWait !== 1'b1) begin n_fail++; $display("FAIL fdw_iwait_pulse: got %b want 1", out_InstructionWait); end
    n_checks++; if (out_MemAddress !== 32'h8) begin n_fail++; $display("FAIL fdw_addr_pulse: got %h want 8", out_MemAddress); end
    next_cycle();
    in_ChangePC = 1'b0;
    settle();
    n_checks++; if (fsm_state !== 1'b1) begin n_fail++; $display("FAIL fdw_discard_state: got %b want 1", fsm_state); end
    n_checks++; if (out_MemRequest !== 1'b1) begin n_fail++; $display("FAIL fdw_discard_req: got %b want 1", out_MemRequest); end
    n_checks++; if (out_MemAddress !== 32'h8) begin n_fail++; $display("FAIL fdw_discard_addr: got %h want 8", out_MemAddress); end
    n_checks++; if (out_InstructionWait !== 1'b1) begin n_fail++; $display("FAIL fdw_flushed_iwait: got %b want 1", out_InstructionWait); end
    next_cycle();
    in_MemWait = 1'b0;
    settle();
    n_checks++; if (out_MemAddress !== 32'h8) begin n_fail++; $display("FAIL fdw_complete_addr: got %h want 8", out_MemAddress); end
    next_cycle();
    settle();
    n_checks++; if (fsm_state !== 1'b0) begin n_fail++; $display("FAIL fdw_back_state: got %b want 0", fsm_state); end
    n_checks++; if (out_MemAddress !== 32'h100) begin n_fail++; $display("FAIL fdw_new_addr: got %h want 100", out_MemAddress); end
    n_checks++; if (out_InstructionWait !== 1'b1) begin n_fail++; $display("FAIL fdw_dropped_iwait: got %b want 1", out_InstructionWait); end
    next_cycle();
    settle();
    n_checks++; if (out_InstructionAddress !== 32'h100) begin n_fail++; $display("FAIL fdw_first_head: got %h want 100", out_InstructionAddress); end
    n_checks++; if (out_Instruction !== mem_word(32'h100)) begin n_fail++; $display("FAIL fdw_first_instr: got %h want %h", out_Instruction, mem_word(32'h100)); end
  endtask

  task automatic test_flush_on_completion;
    apply_reset();
    repeat (3) next_cycle();
    in_ChangePC = 1'b1;
    in_NewPC = 32'h200;
    settle();
    n_checks++; if (out_MemAddress !== 32'hC) begin n_fail++; $display("FAIL foc_addr: got %h want c", out_MemAddress); end
    n_checks++; if (out_InstructionWait !== 1'b1) begin n_fail++; $display("FAIL foc_iwait: got %b want 1", out_InstructionWait); end
    next_cycle();
    in_ChangePC = 1'b0;
    settle();
    n_checks++; if (fsm_state !== 1'b0) begin n_fail++; $display("FAIL foc_state: got %b want 0", fsm_state); end
    n_checks++; if (out_MemAddress !== 32'h200) begin n_fail++; $display("FAIL foc_new_addr: got %h want 200", out_MemAddress); end
    n_checks++; if (out_Instruction !== 32'h0) begin n_fail++; $display("FAIL foc_empty_instr: got %h want 0", out_Instruction); end
    next_cycle();
    settle();
    n_checks++; if (out_InstructionAddress !== 32'h200) begin n_fail++; $display("FAIL foc_head: got %h want 200", out_InstructionAddress); end
    n_checks++; if (out_Instruction !== mem_word(32'h200)) begin n_fail++; $display("FAIL foc_instr: got %h want %h", out_Instruction, mem_word(32'h200)); end
  endtask

  task automatic test_async_reset;
    apply_reset();
    repeat (3) next_cycle();
    in_MemWait = 1'b1;
    settle();
    n_checks++; if (out_InstructionWait !== 1'b0) begin n_fail++; $display("FAIL ar_pre_iwait: got %b want 0", out_InstructionWait); end
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (out_MemRequest !== 1'b0) begin n_fail++; $display("FAIL ar_req: got %b want 0", out_MemRequest); end
    n_checks++; if (out_InstructionWait !== 1'b1) begin n_fail++; $display("FAIL ar_iwait: got %b want 1", out_InstructionWait); end
    n_checks++; if (out_Instruction !== 32'h0) begin n_fail++; $display("FAIL ar_instr: got %h want 0", out_Instruction); end
    n_checks++; if (out_InstructionAddress !== 32'h0) begin n_fail++; $display("FAIL ar_iaddr: got %h want 0", out_InstructionAddress); end
    next_cycle();
    in_MemWait = 1'b0;
    reset = 1'b1;
    settle();
    n_checks++; if (out_MemRequest !== 1'b1) begin n_fail++; $display("FAIL ar_restart_req: got %b want 1", out_MemRequest); end
    n_checks++; if (out_MemAddress !== 32'h0) begin n_fail++; $display("FAIL ar_restart_addr: got %h want 0", out_MemAddress); end
    next_cycle();
    settle();
    n_checks++; if (out_InstructionAddress !== 32'h0) begin n_fail++; $display("FAIL ar_head: got %h want 0", out_InstructionAddress); end
    n_checks++; if (out_Instruction !== mem_word(32'h0)) begin n_fail++; $display("FAIL ar_instr_after: got %h want %h", out_Instruction, mem_word(32'h0)); end
    n_checks++; if (out_MemAddress !== 32'h4) begin n_fail++; $display("FAIL ar_next_addr: got %h want 4", out_MemAddress); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_fetch_from_reset();
    test_full_with_pop();
    test_back_to_back();
    test_flush_during_wait();
    test_flush_on_completion();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
